// File: rtl/hc_pkg.sv
// hc_pkg: shared types and default sizing for the Hamming decoder monitor stage.
package hc_pkg;
    localparam int DATA_WD    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_WD     = 8;
    localparam int WIN_LEN    = 16;
    localparam int ERR_THR    = 3;
    localparam int PTR_WD     = $clog2(FIFO_DEPTH) + 1;
    localparam int WIN_WD     = $clog2(WIN_LEN);
    typedef enum logic {MONITOR, ALARM} hc_mon_state_e;
    typedef struct packed {
        logic               err;
        logic [DATA_WD-1:0] data;
    } hc_mon_entry_t;
endpackage

// File: rtl/hc_dec_mon_if.sv
// hc_dec_mon_if: upstream/downstream handshakes plus monitor status of the decoder monitor stage.
interface hc_dec_mon_if #(parameter int DATA_WD = 4, parameter int CNT_WD = 8);
    logic               in_valid;
    logic               in_ready;
    logic [DATA_WD:1]   dec_data;
    logic               err_flag;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_WD:1]   data;
    logic               data_err;
    logic [CNT_WD:1]    word_cnt;
    logic [CNT_WD:1]    err_cnt;
    logic               alarm;
    logic               alarm_clr;
    modport slave (
        input  in_valid, dec_data, err_flag, out_ready, alarm_clr,
        output in_ready, out_valid, data, data_err, word_cnt, err_cnt, alarm
    );
    modport master (
        output in_valid, dec_data, err_flag, out_ready, alarm_clr,
        input  in_ready, out_valid, data, data_err, word_cnt, err_cnt, alarm
    );
endinterface

// File: rtl/hc_sync_fifo.sv
// hc_sync_fifo: generic synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module hc_sync_fifo #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    output logic              full,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              do_push, do_pop;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Storage is not reset, so the head is forced to zero while empty.
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/hc_dec_mon.sv
// hc_dec_mon: buffers decoded words, keeps saturating totals and raises a sticky windowed error-rate alarm.
module hc_dec_mon
    import hc_pkg::*;
#(
    parameter int DATA_WD    = hc_pkg::DATA_WD,
    parameter int FIFO_DEPTH = hc_pkg::FIFO_DEPTH,
    parameter int CNT_WD     = hc_pkg::CNT_WD,
    parameter int WIN_LEN    = hc_pkg::WIN_LEN,
    parameter int ERR_THR    = hc_pkg::ERR_THR
) (
    input logic          i_clk,
    input logic          i_rst,
    hc_dec_mon_if.slave  bus
);
    localparam int WW = $clog2(WIN_LEN);
    localparam int EW = $clog2(ERR_THR + 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_LEN - 1);
    localparam logic [EW-1:0] THR_M1   = EW'(ERR_THR - 1);
    logic            full, empty, push;
    logic [CNT_WD:1] word_cnt, err_cnt;
    logic [WW-1:0]   win_cnt;
    logic [EW-1:0]   win_err;
    logic            alarm;
    hc_mon_state_e   state;
    hc_sync_fifo #(.DATA_W(DATA_WD + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (bus.in_valid),
        .wdata ({bus.err_flag, bus.dec_data}),
        .full  (full),
        .pop   (bus.out_ready),
        .rdata ({bus.data_err, bus.data}),
        .empty (empty)
    );
    assign push          = bus.in_valid && !full;
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.word_cnt  = word_cnt;
    assign bus.err_cnt   = err_cnt;
    assign bus.alarm     = alarm;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word_cnt <= '0;
            err_cnt  <= '0;
        end else if (push) begin
            if (!(&word_cnt)) word_cnt <= word_cnt + 1'b1;
            if (bus.err_flag && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
        end
    end
    // Threshold is tested before window wrap so the last word of a window can still fire.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.alarm_clr) begin
            state   <= MONITOR;
            alarm   <= 1'b0;
            win_cnt <= '0;
            win_err <= '0;
        end else if (state == MONITOR && push) begin
            if (bus.err_flag && win_err == THR_M1) begin
                state   <= ALARM;
                alarm   <= 1'b1;
                win_err <= EW'(ERR_THR);
            end else if (win_cnt == WIN_LAST) begin
                win_cnt <= '0;
                win_err <= '0;
            end else begin
                win_cnt <= win_cnt + 1'b1;
                win_err <= win_err + EW'(bus.err_flag);
            end
        end
    end
endmodule

// File: tb/tb_hc_dec_mon.sv
// tb_hc_dec_mon: directed and random stimulus against a queue-based reference model with a negedge scoreboard.
module tb_hc_dec_mon;
    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int WLEN  = 16;
    localparam int THR   = 3;
    localparam int CMAX  = (1 << CW) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    hc_pkg::hc_mon_entry_t exp_q[$];
    int   m_words, m_errs, m_n, m_e;
    bit   m_alarm;
    always #5 clk = ~clk;
    hc_dec_mon_if #(.DATA_WD(DW), .CNT_WD(CW)) bus ();
    hc_dec_mon #(
        .DATA_WD(DW), .FIFO_DEPTH(DEPTH), .CNT_WD(CW), .WIN_LEN(WLEN), .ERR_THR(THR)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );
    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // Reference model: FIFO contents as a queue, totals and window as plain counts.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_words = 0; m_errs = 0; m_n = 0; m_e = 0; m_alarm = 0;
        end else begin
            bit psh, pp;
            psh = bus.in_valid && exp_q.size() < DEPTH;
            pp  = bus.out_ready && exp_q.size() > 0;
            if (pp) void'(exp_q.pop_front());
            if (psh) begin
                hc_pkg::hc_mon_entry_t e;
                e.err = bus.err_flag;
                e.data = bus.dec_data;
                exp_q.push_back(e);
                if (m_words < CMAX) m_words++;
                if (bus.err_flag && m_errs < CMAX) m_errs++;
            end
            if (bus.alarm_clr) begin
                m_alarm = 0; m_n = 0; m_e = 0;
            end else if (!m_alarm && psh) begin
                m_n++;
                if (bus.err_flag) m_e++;
                if (m_e == THR) m_alarm = 1;
                else if (m_n == WLEN) begin m_n = 0; m_e = 0; end
            end
        end
    end
    initial forever begin
        @(negedge clk);
        chk("in_ready", bus.in_ready, exp_q.size() < DEPTH);
        chk("out_valid", bus.out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            chk("data", bus.data, exp_q[0].data);
            chk("data_err", bus.data_err, exp_q[0].err);
        end
        chk("word_cnt", bus.word_cnt, m_words);
        chk("err_cnt", bus.err_cnt, m_errs);
        chk("alarm", bus.alarm, m_alarm);
    end
    task automatic cyc(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic do_reset(int n);
        rst = 1'b1; cyc(n); rst = 1'b0;
    endtask
    task automatic put(int d, bit f, bit clr = 1'b0);
        bus.in_valid = 1'b1; bus.dec_data = DW'(d); bus.err_flag = f; bus.alarm_clr = clr;
        cyc();
        bus.in_valid = 1'b0; bus.err_flag = 1'b0; bus.alarm_clr = 1'b0;
    endtask
    initial begin
        bus.in_valid = 0; bus.dec_data = 0; bus.err_flag = 0; bus.out_ready = 0; bus.alarm_clr = 0;
        do_reset(2);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.data, 0);
        chk("rst_words", bus.word_cnt, 0);
        chk("rst_alarm", bus.alarm, 0);
        bus.out_ready = 1;
        put(1, 0);
        chk("lat_valid", bus.out_valid, 1);
        chk("lat_data1", bus.data, 1);
        put(2, 1);
        chk("lat_data2", bus.data, 2);
        chk("lat_err2", bus.data_err, 1);
        put(3, 0);
        chk("lat_data3", bus.data, 3);
        cyc(2);
        do_reset(1);
        bus.out_ready = 0;
        for (int i = 0; i < DEPTH; i++) put(i + 5, i[0]);
        chk("full_ready", bus.in_ready, 0);
        put(15, 1);
        chk("full_words", bus.word_cnt, 4);
        chk("full_head", bus.data, 5);
        bus.out_ready = 1;
        for (int i = 0; i < 8; i++) put(i + 8, 0);
        cyc(6);
        bus.out_ready = 0;
        for (int i = 0; i < 3; i++) put(i + 1, 0);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("midrst_valid", bus.out_valid, 0);
        bus.out_ready = 1;
        for (int i = 1; i <= 16; i++) begin
            put(i, i == 2 || i == 7 || i == 9);
            if (i == 8) chk("alarm_early", bus.alarm, 0);
            if (i == 9) chk("alarm_fire", bus.alarm, 1);
        end
        chk("alarm_errs", bus.err_cnt, 3);
        do_reset(1);
        for (int i = 1; i <= 17; i++) put(i, i == 2 || i == 7 || i == 17);
        chk("wrap_noalarm", bus.alarm, 0);
        do_reset(1);
        for (int i = 0; i < 3; i++) put(i, 1);
        chk("clr_pre", bus.alarm, 1);
        put(9, 1, 1);
        chk("clr_alarm", bus.alarm, 0);
        chk("clr_errs", bus.err_cnt, 4);
        put(1, 1); put(2, 1);
        chk("clr_uncounted", bus.alarm, 0);
        put(3, 1);
        chk("clr_refire", bus.alarm, 1);
        do_reset(1);
        for (int i = 0; i < 10; i++) put(i, 1, bus.alarm);
        chk("sat_words", bus.word_cnt, CMAX);
        chk("sat_errs", bus.err_cnt, CMAX);
        do_reset(1);
        for (int i = 0; i < 800; i++) begin
            rst           = $urandom_range(0, 149) == 0;
            bus.in_valid  = $urandom_range(0, 3) != 0;
            bus.out_ready = $urandom_range(0, 2) != 0;
            bus.dec_data  = DW'($urandom);
            bus.err_flag  = $urandom_range(0, 3) == 0;
            bus.alarm_clr = $urandom_range(0, 24) == 0;
            cyc();
        end
        rst = 0; bus.in_valid = 0; bus.alarm_clr = 0; bus.out_ready = 1;
        cyc(6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
